pdm_bit_packer: RTL and testbench
=================================

// Module: pdm_bit_packer
// PURPOSE
//  Downstream of the PDM clock generator. Samples the MEMS mic 1-bit PDM data on the mic-clock rising-edge strobe.
//  Packs bits MSB-first into WORD_W words and buffers them in a small FIFO.
//  Presents the words as an AXI-Stream master to the CIC decimation stage.
//  Discards WARMUP_WORDS words after each enable to cover mic start-up.
// PARAMETERS
//  WORD_W        16   bits per output word (>=2)
//  FIFO_DEPTH    8    output FIFO entries (power of 2, >=2)
//  SYNC_STAGES   2    flops on mic_data synchronizer (>=2)
//  WARMUP_WORDS  4    packed words discarded after en rises (0 = none)
// PORTS
//  clk            in   1       system clock
//  rst            in   1       synchronous, active-high reset
//  en             in   1       capture enable
//  sample_stb     in   1       1-cycle pulse at mic_clk rising edge (clk_rising)
//  mic_data       in   1       asynchronous PDM data from microphone
//  m_axis_tdata   out  WORD_W  packed PDM bits, first-sampled bit in MSB
//  m_axis_tvalid  out  1       FIFO not empty
//  m_axis_tready  in   1       downstream accept
//  overflow       out  1       sticky: a word was dropped on a full FIFO
//  busy           out  1       FSM not IDLE
// BEHAVIOUR
//  Reset: tdata=0, tvalid=0, overflow=0, busy=0; FIFO empty; shift reg, bit count and warm-up count all 0; FSM=IDLE.
//  mic_data passes through a SYNC_STAGES synchronizer. sample_stb is delayed by SYNC_STAGES cycles, so each sample is
//    the mic_data value present at the undelayed strobe.
//  FSM IDLE: en=1 -> WARMUP if WARMUP_WORDS>0, else RUN.
//  FSM WARMUP: packs words but discards them; after WARMUP_WORDS words -> RUN.
//  FSM RUN: each completed word is pushed to the FIFO.
//  In WARMUP or RUN, en=0 -> IDLE next cycle. The partial word is discarded; the FIFO contents are kept and still drain.
//  Packing: on each delayed strobe, shreg <= {shreg[WORD_W-2:0], bit} and bitcnt increments.
//    When bitcnt==WORD_W-1, the word completes that same cycle and bitcnt wraps to 0.
//  Push latency: the completed word is visible on tdata with tvalid=1 one cycle after the completing strobe, if the FIFO was empty.
//  AXIS rules: transfer when tvalid&&tready. tdata/tvalid are held stable while tvalid&&!tready.
//    tvalid never depends combinationally on tready.
//  Full FIFO at push: the new word is dropped, FIFO contents are unchanged, and overflow is set. overflow clears only on rst.
//  Simultaneous push and pop on a full FIFO: the pop frees a slot, so the push succeeds and there is no overflow.
//  Simultaneous push and pop on an empty FIFO: pop is impossible (tvalid=0); the push succeeds.
//  Strobe while en=0: ignored.
//  Reset mid-word or mid-transfer: everything returns to reset values next cycle and the FIFO is emptied.
//  Pointers are log2(FIFO_DEPTH)+1 bits. Full/empty come from the MSB compare; pointer wrap-around is natural overflow.
// CONFIGURATION
//  PDM_DROP_CNT_EN defined: adds port drop_cnt out 16. It is a saturating count (stops at 16'hFFFF) of dropped words.
//    It resets to 0 on rst and is unaffected by en.
//  PDM_DROP_CNT_EN undefined: no drop_cnt port and no counter logic; overflow flag only.
// STRUCTURE
//  pdm_pkg: typedef enum logic [1:0] {IDLE, WARMUP, RUN} pdm_state_e; localparam defaults for WORD_W/FIFO_DEPTH.
//  Sub-module pdm_sync_fifo (WIDTH, DEPTH): synchronous FIFO with push/pop/full/empty and registered read data.
//  Top level holds the synchronizer, strobe delay line, FSM, shift register and overflow logic.
// TESTING
//  1 WORD_W=16, WARMUP_WORDS=0, tready=1, mic_data=1 for 16 strobes -> one beat tdata=16'hFFFF, overflow=0.
//  2 Alternating bits starting with 1, 16 strobes -> tdata=16'hAAAA. A first bit 0 gives 16'h5555.
//  3 WARMUP_WORDS=4: en rises, 80 strobes -> exactly 1 beat out (the 5th word); busy=1 from the cycle after en.
//  4 tready=0, FIFO_DEPTH=8, 9 words -> 8 held, overflow=1; with PDM_DROP_CNT_EN, drop_cnt=1.
//    Then raise tready -> the 8 words drain in order, tvalid falls after the 8th.
//  5 Full FIFO; pop and word completion in the same cycle -> no overflow, FIFO stays at 8.
//  6 en drops after 7 bits -> no beat. Re-enable and send 16 bits -> a clean word with no leftover bits.
//    rst mid-word -> all outputs at reset values.

Source files
------------

// File: rtl/pdm_pkg.sv
// Purpose: shared types and default parameters for the PDM bit packer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pdm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } pdm_state_e;

    localparam int WORD_W_DEF       = 16;
    localparam int FIFO_DEPTH_DEF   = 8;
    localparam int SYNC_STAGES_DEF  = 2;
    localparam int WARMUP_WORDS_DEF = 4;

endpackage

// File: rtl/pdm_sync_fifo.sv
// Purpose: synchronous FIFO with a registered head-of-queue output (pop_dat always shows the oldest entry).
// Latency: a push into an empty FIFO is visible on pop_dat/!empty the next clk.
// Backpressure: push on full is ignored unless a pop happens in the same cycle; pop on empty is ignored.
// Ports: clk, rst (sync, active-high), push/push_dat, pop/pop_dat, full, empty.
module pdm_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_nxt;
    logic             do_push;
    logic             do_pop;
    logic             one_left;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop     = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push    = push && (!full || do_pop);
    assign rd_ptr_nxt = rd_ptr_q + PTR_ONE;
    assign one_left   = ((wr_ptr_q - rd_ptr_q) == PTR_ONE);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pop_dat  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            // Keep pop_dat equal to the head entry. When the last stored word
            // leaves while a new one arrives, the new word bypasses the RAM.
            if (do_pop) begin
                if (!one_left) begin
                    pop_dat <= mem[rd_ptr_nxt[AW-1:0]];
                end else if (do_push) begin
                    pop_dat <= push_dat;
                end
            end else if (empty && do_push) begin
                pop_dat <= push_dat;
            end
        end
    end

endmodule

// File: rtl/pdm_bit_packer.sv
// Purpose: samples 1-bit PDM mic data on the mic-clock strobe, packs MSB-first words, streams them out over AXI-Stream.
// Latency: word appears on m_axis_tdata one clk after its completing (SYNC_STAGES-delayed) strobe if the FIFO was empty.
// Backpressure: FIFO_DEPTH words absorb m_axis_tready stalls; a word completing on a full FIFO is dropped, overflow sticks.
// Ports: clk, rst (sync, active-high), en, sample_stb, mic_data (async), m_axis_tdata/tvalid/tready, overflow, busy.
// Optional: define PDM_DROP_CNT_EN to add drop_cnt[15:0], a saturating count of dropped words.
module pdm_bit_packer
    import pdm_pkg::*;
#(
    parameter int WORD_W       = WORD_W_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int WARMUP_WORDS = WARMUP_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sample_stb,
    input  logic              mic_data,
    output logic [WORD_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              overflow,
    output logic              busy
`ifdef PDM_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam int WU_W = (WARMUP_WORDS > 1) ? $clog2(WARMUP_WORDS) : 1;
    localparam logic [WU_W-1:0] WU_LAST = WU_W'((WARMUP_WORDS > 0) ? (WARMUP_WORDS - 1) : 0);

    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [SYNC_STAGES-1:0] stb_dly_q;
    logic                   mic_bit;
    logic                   stb_vld;

    pdm_state_e             state_q;
    pdm_state_e             state_d;

    logic [WORD_W-1:0]      shreg_q;
    logic [CNT_W-1:0]       bitcnt_q;
    logic [WU_W-1:0]        warm_cnt_q;
    logic [WORD_W-1:0]      word_dat;
    logic                   capture;
    logic                   word_done;
    logic                   push_vld;
    logic                   pop_vld;
    logic                   fifo_full;
    logic                   fifo_empty;

    // The strobe is delayed by the same number of flops as the data so each
    // sample is the mic_data value present at the original strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_sync_q <= '0;
            stb_dly_q   <= '0;
        end else begin
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], mic_data};
            stb_dly_q   <= {stb_dly_q[SYNC_STAGES-2:0], sample_stb};
        end
    end

    assign mic_bit   = data_sync_q[SYNC_STAGES-1];
    assign stb_vld   = stb_dly_q[SYNC_STAGES-1];

    assign capture   = (state_q != IDLE) && en && stb_vld;
    assign word_done = capture && (bitcnt_q == LAST_BIT);
    assign word_dat  = {shreg_q[WORD_W-2:0], mic_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        push_vld = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    if (WARMUP_WORDS > 0) begin
                        state_d = WARMUP;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            WARMUP: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (word_done && (warm_cnt_q == WU_LAST)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    push_vld = word_done;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Packing state is held cleared whenever capture is not active, so a
    // disable always discards the partial word and re-enable starts clean.
    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE) || !en) begin
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            warm_cnt_q <= '0;
        end else if (stb_vld) begin
            shreg_q  <= word_dat;
            bitcnt_q <= word_done ? '0 : bitcnt_q + 1'b1;
            if ((state_q == WARMUP) && word_done) begin
                warm_cnt_q <= warm_cnt_q + 1'b1;
            end
        end
    end

    assign m_axis_tvalid = !fifo_empty;
    assign pop_vld       = m_axis_tvalid && m_axis_tready;
    assign busy          = (state_q != IDLE);

    pdm_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_vld),
        .push_dat (word_dat),
        .pop      (pop_vld),
        .pop_dat  (m_axis_tdata),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push_vld && fifo_full && !pop_vld) begin
            overflow <= 1'b1;
        end
    end

`ifdef PDM_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (push_vld && fifo_full && !pop_vld && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pdm_bit_packer.sv
module tb_pdm_bit_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        = 1'b1;
    logic        en0        = 1'b0;
    logic        en4        = 1'b0;
    logic        sample_stb = 1'b0;
    logic        mic_data   = 1'b0;
    logic        tready0    = 1'b0;
    logic [15:0] tdata0, tdata4;
    logic        tvalid0, tvalid4, ovf0, ovf4, busy0, busy4;
`ifdef PDM_DROP_CNT_EN
    logic [15:0] drop0, drop4;
`endif

    pdm_bit_packer #(.WORD_W(16), .FIFO_DEPTH(8), .SYNC_STAGES(2), .WARMUP_WORDS(0)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .sample_stb(sample_stb), .mic_data(mic_data),
        .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready0),
        .overflow(ovf0), .busy(busy0)
`ifdef PDM_DROP_CNT_EN
        , .drop_cnt(drop0)
`endif
    );

    pdm_bit_packer #(.WORD_W(16), .FIFO_DEPTH(8), .SYNC_STAGES(2), .WARMUP_WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .sample_stb(sample_stb), .mic_data(mic_data),
        .m_axis_tdata(tdata4), .m_axis_tvalid(tvalid4), .m_axis_tready(1'b1),
        .overflow(ovf4), .busy(busy4)
`ifdef PDM_DROP_CNT_EN
        , .drop_cnt(drop4)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of dut0 (WARMUP_WORDS=0) ----------------
    // A sample counts if the strobe (seen two edges earlier) lands while the block
    // has been enabled for two consecutive edges; 16 samples form a word; the
    // output queue holds 8 words, a pop at the same edge makes room for a push.
    logic [15:0] mq[$];
    logic [15:0] got0[$];
    logic [15:0] got4[$];
    logic [15:0] pword = '0;
    int          pbits = 0;
    bit          movf = 0;
    int          mdrop = 0;
    bit          prev_act = 0;
    bit          h_stb0 = 0, h_stb1 = 0, h_bit0 = 0, h_bit1 = 0;
    bit          v_prev = 0, v4_prev = 0;
    logic [15:0] d_prev = '0, d4_prev = '0;
    bit          s_rst, s_en, s_stb, s_bit, s_rdy;

    always begin
        @(posedge clk);
        s_rst = rst; s_en = en0; s_stb = sample_stb; s_bit = mic_data; s_rdy = tready0;
        if (!s_rst && v_prev && s_rdy) got0.push_back(d_prev);
        if (!s_rst && v4_prev) got4.push_back(d4_prev);
        if (s_rst) begin
            mq.delete();
            pbits = 0; pword = '0; movf = 0; mdrop = 0;
        end else begin
            if (mq.size() > 0 && s_rdy) void'(mq.pop_front());
            if (prev_act && s_en) begin
                if (h_stb1) begin
                    pword = {pword[14:0], h_bit1};
                    pbits++;
                    if (pbits == 16) begin
                        pbits = 0;
                        if (mq.size() < 8) mq.push_back(pword);
                        else begin
                            movf = 1;
                            if (mdrop < 65535) mdrop++;
                        end
                    end
                end
            end else begin
                pbits = 0; pword = '0;
            end
        end
        h_stb1 = h_stb0; h_bit1 = h_bit0;
        h_stb0 = s_rst ? 1'b0 : s_stb;
        h_bit0 = s_rst ? 1'b0 : s_bit;
        prev_act = !s_rst && s_en;
        #1;
        check("tvalid", {31'd0, tvalid0}, {31'd0, mq.size() > 0});
        if (mq.size() > 0) check("tdata", {16'd0, tdata0}, {16'd0, mq[0]});
        check("overflow", {31'd0, ovf0}, {31'd0, movf});
        check("busy", {31'd0, busy0}, {31'd0, prev_act});
`ifdef PDM_DROP_CNT_EN
        check("drop_cnt", {16'd0, drop0}, mdrop);
`endif
        v_prev = tvalid0; d_prev = tdata0;
        v4_prev = tvalid4; d4_prev = tdata4;
    end

    function automatic logic [31:0] beat0(input int i);
        return (i < got0.size()) ? {16'd0, got0[i]} : 32'hBAD0_0000;
    endfunction

    function automatic logic [31:0] beat4(input int i);
        return (i < got4.size()) ? {16'd0, got4[i]} : 32'hBAD0_0000;
    endfunction

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One mic-clock period of 4 core cycles; pulse raises tready0 for exactly
    // the edge at which this bit's delayed strobe is captured.
    task automatic send_bit(input logic b, input bit pulse);
        @(negedge clk); mic_data = b; sample_stb = 1'b1;
        @(negedge clk); sample_stb = 1'b0;
        @(negedge clk); if (pulse) tready0 = 1'b1;
        @(negedge clk); if (pulse) tready0 = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i], 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; en0 = 1'b0; en4 = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    int n0, n4;
    logic [3:0] nib;
    logic [15:0] w9;

    initial begin
        cycles(2);
        check("rst_tvalid", {31'd0, tvalid0}, 0);
        check("rst_tdata", {16'd0, tdata0}, 0);
        check("rst_overflow", {31'd0, ovf0}, 0);
        check("rst_busy", {31'd0, busy0}, 0);
        rst = 1'b0;

        // all ones
        tready0 = 1'b1; en0 = 1'b1; cycles(3);
        n0 = got0.size();
        for (int i = 0; i < 16; i++) send_bit(1'b1, 1'b0);
        cycles(4);
        check("t1_beats", got0.size() - n0, 1);
        check("t1_word", beat0(n0), 32'h0000_FFFF);
        check("t1_overflow", {31'd0, ovf0}, 0);

        // alternating, first bit 1 then first bit 0
        n0 = got0.size();
        for (int i = 0; i < 16; i++) send_bit(~i[0], 1'b0);
        for (int i = 0; i < 16; i++) send_bit(i[0], 1'b0);
        cycles(4);
        check("t2_beats", got0.size() - n0, 2);
        check("t2_aaaa", beat0(n0), 32'h0000_AAAA);
        check("t2_5555", beat0(n0 + 1), 32'h0000_5555);

        // warm-up on the WARMUP_WORDS=4 instance
        en0 = 1'b0; cycles(2);
        check("t3_busy_before", {31'd0, busy4}, 0);
        en4 = 1'b1;
        @(negedge clk);
        check("t3_busy_after", {31'd0, busy4}, 1);
        n4 = got4.size();
        send_word(16'h1111); send_word(16'h2222); send_word(16'h3333);
        send_word(16'h4444); send_word(16'hBEEF);
        cycles(4);
        check("t3_beats", got4.size() - n4, 1);
        check("t3_word", beat4(n4), 32'h0000_BEEF);
        check("t3_overflow", {31'd0, ovf4}, 0);
        en4 = 1'b0;

        // fill with tready low, 9th word dropped, then drain in order
        do_reset();
        en0 = 1'b1; tready0 = 1'b0; cycles(3);
        n0 = got0.size();
        for (int k = 1; k <= 9; k++) begin
            nib = k[3:0];
            send_word({4{nib}});
        end
        cycles(4);
        check("t4_overflow", {31'd0, ovf0}, 1);
        check("t4_tvalid", {31'd0, tvalid0}, 1);
        check("t4_no_beats", got0.size() - n0, 0);
`ifdef PDM_DROP_CNT_EN
        check("t4_drop_cnt", {16'd0, drop0}, 1);
`endif
        tready0 = 1'b1; cycles(12);
        check("t4_drained", got0.size() - n0, 8);
        for (int k = 1; k <= 8; k++) begin
            nib = k[3:0];
            check("t4_order", beat0(n0 + k - 1), {16'd0, {4{nib}}});
        end
        check("t4_tvalid_low", {31'd0, tvalid0}, 0);

        // full FIFO, pop coincides with word completion
        do_reset();
        en0 = 1'b1; tready0 = 1'b0; cycles(3);
        n0 = got0.size();
        for (int k = 1; k <= 8; k++) begin
            nib = k[3:0];
            send_word({4{nib}});
        end
        w9 = 16'hC3C3;
        for (int i = 15; i >= 1; i--) send_bit(w9[i], 1'b0);
        send_bit(w9[0], 1'b1);
        cycles(2);
        check("t5_overflow", {31'd0, ovf0}, 0);
        check("t5_one_pop", got0.size() - n0, 1);
        check("t5_first", beat0(n0), 32'h0000_1111);
        tready0 = 1'b1; cycles(12);
        check("t5_total", got0.size() - n0, 9);
        check("t5_last", beat0(n0 + 8), 32'h0000_C3C3);
        check("t5_overflow_end", {31'd0, ovf0}, 0);

        // disable mid-word, re-enable, then reset mid-word
        do_reset();
        en0 = 1'b1; tready0 = 1'b1; cycles(3);
        n0 = got0.size();
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        cycles(2); en0 = 1'b0; cycles(4);
        check("t6_no_beat", got0.size() - n0, 0);
        check("t6_busy_off", {31'd0, busy0}, 0);
        en0 = 1'b1; cycles(3);
        send_word(16'h0F0F);
        cycles(4);
        check("t6_beats", got0.size() - n0, 1);
        check("t6_clean", beat0(n0), 32'h0000_0F0F);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        @(negedge clk); rst = 1'b1; en0 = 1'b0;
        @(negedge clk);
        check("t6_rst_tdata", {16'd0, tdata0}, 0);
        check("t6_rst_tvalid", {31'd0, tvalid0}, 0);
        check("t6_rst_overflow", {31'd0, ovf0}, 0);
        check("t6_rst_busy", {31'd0, busy0}, 0);
        rst = 1'b0;
        cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
